bp_me_mock_mem_responder: RTL and testbench
===========================================

Name: bp_me_mock_mem_responder

Overview:
Non-synthesizable memory-side responder for CCE unit benches: the other end of the CCE memory command/response interface. It accepts one memory command at a time, services it against a small internal block store after a fixed latency, and returns exactly one response per command. It sits where a DRAM model would sit, downstream of the CCE mem_cmd buffer and upstream of the mem_resp buffer, giving deterministic latency and bench-visible state.

Parameters:
addr_width_p, 40, physical address width
block_width_p, 512, cache block width in bits; byte offset = log2(block_width_p/8) bits
payload_width_p, 16, opaque command payload; echoed unchanged in the response
els_p, 64, blocks stored; index = addr bits directly above the byte offset, modulo els_p (aliases wrap)
latency_p, 4, cycles from command accept to mem_resp_v_o rising; legal range is 1 or more

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
mem_cmd_v_i  in  1  command valid
mem_cmd_ready_o  out  1  responder can accept a command (ready/valid)
mem_cmd_opcode_i  in  2  0=rd block, 1=wr block, 2=uc_rd, 3=uc_wr
mem_cmd_addr_i  in  addr_width_p  byte address
mem_cmd_size_i  in  3  log2 bytes for uncached ops, 0..log2(block bytes)
mem_cmd_payload_i  in  payload_width_p  opaque, echoed
mem_cmd_data_i  in  block_width_p  write data; uc_wr uses the low 2^size bytes
mem_resp_v_o  out  1  response valid
mem_resp_yumi_i  in  1  response consumed (valid-then-yumi)
mem_resp_opcode_o  out  2  echo of the command opcode
mem_resp_addr_o  out  addr_width_p  echo of the command address
mem_resp_size_o  out  3  echo of the command size
mem_resp_payload_o  out  payload_width_p  echo of the command payload
mem_resp_data_o  out  block_width_p  read data; zero for writes
cmd_count_o  out  32  count of completed responses (yumi'd); wraps at 2^32

Behaviour:
- Reset (async, reset_n_i=0): state=eReady, mem_cmd_ready_o=1 after reset deasserts (0 while asserted), mem_resp_v_o=0, all response fields 0, cmd_count_o=0, store cleared to zero. A pending command or response is dropped with no response.
- FSM states: eReady, eWait, eResp.
- eReady: mem_cmd_ready_o=1. A command is accepted when mem_cmd_v_i&ready. On accept, latch opcode/addr/size/payload.
  - Writes take effect in the accept cycle: wr overwrites the whole indexed block; uc_wr writes 2^size bytes at byte offset addr aligned down to 2^size, taken from the low bytes of data_i.
  - Reads sample the store at response formation, so a read observes every earlier write.
  - Transition: to eResp if latency_p==1; otherwise to eWait with counter=latency_p-2.
- eWait: mem_cmd_ready_o=0. Counter decrements; at 0 go to eResp. mem_resp_v_o therefore rises exactly latency_p cycles after the accept edge.
- eResp: mem_resp_v_o=1. All response fields are held stable until yumi.
  - rd: data = full indexed block.
  - uc_rd: the selected 2^size bytes right-justified, upper bits 0.
  - wr/uc_wr: data = 0.
  - On mem_resp_yumi_i: cmd_count_o increments, go to eReady. Ready is 1 the following cycle, so the minimum command period is latency_p+1 cycles.
- mem_resp_yumi_i while mem_resp_v_o=0 is ignored; mem_cmd_v_i while not ready is ignored. The bench must hold mem_cmd_v_i until ready.
- Address bits above index+offset are ignored (alias). Response address is the original, unaligned, echo.
- Size greater than log2(block bytes) is treated as full-block.
- Simulation assertion: yumi without valid, or latency_p<1, triggers $error.

Test Plan:
- Reset then idle -> mem_cmd_ready_o=1, mem_resp_v_o=0, cmd_count_o=0; rd at addr 0x0 returns data 0 exactly 4 cycles after accept.
- wr block addr 0x40 data={16{32'hDEADBEEF}}, then rd 0x40 -> resp data equals written block, payload echoed; cmd_count_o=2.
- uc_wr addr 0x86 size=1 data low 16b=0xA5C3, then uc_rd addr 0x86 size=1 -> data=0x000..A5C3; rd 0x80 -> bytes 6-7 =C3,A5, rest 0.
- Aliasing, els_p=64: wr 0x0 then rd addr 64*64=0x1000 -> same block returned; resp_addr_o=0x1000.
- Backpressure: hold yumi low 10 cycles -> mem_resp_v_o and all fields stable, ready=0 throughout; yumi -> ready=1 next cycle.
- Assert reset_n_i during eWait -> resp_v stays 0 and no response emerges; a subsequent rd to a previously written addr returns 0 (store cleared); cmd_count_o=0.

Source files
------------

// File: rtl/bp_me_mock_mem_responder_if.sv
// Memory command/response channel between a CCE and its memory-side responder.
// The master drives commands and consumes responses; the slave is the memory side.
interface bp_me_mock_mem_responder_if
  #(parameter int addr_width_p    = 40
  , parameter int block_width_p   = 512
  , parameter int payload_width_p = 16
  );

  logic                       mem_cmd_v_i;
  logic                       mem_cmd_ready_o;
  logic [1:0]                 mem_cmd_opcode_i;
  logic [addr_width_p-1:0]    mem_cmd_addr_i;
  logic [2:0]                 mem_cmd_size_i;
  logic [payload_width_p-1:0] mem_cmd_payload_i;
  logic [block_width_p-1:0]   mem_cmd_data_i;

  logic                       mem_resp_v_o;
  logic                       mem_resp_yumi_i;
  logic [1:0]                 mem_resp_opcode_o;
  logic [addr_width_p-1:0]    mem_resp_addr_o;
  logic [2:0]                 mem_resp_size_o;
  logic [payload_width_p-1:0] mem_resp_payload_o;
  logic [block_width_p-1:0]   mem_resp_data_o;

  modport master (
    output mem_cmd_v_i, mem_cmd_opcode_i, mem_cmd_addr_i, mem_cmd_size_i,
           mem_cmd_payload_i, mem_cmd_data_i, mem_resp_yumi_i,
    input  mem_cmd_ready_o, mem_resp_v_o, mem_resp_opcode_o, mem_resp_addr_o,
           mem_resp_size_o, mem_resp_payload_o, mem_resp_data_o
  );

  modport slave (
    input  mem_cmd_v_i, mem_cmd_opcode_i, mem_cmd_addr_i, mem_cmd_size_i,
           mem_cmd_payload_i, mem_cmd_data_i, mem_resp_yumi_i,
    output mem_cmd_ready_o, mem_resp_v_o, mem_resp_opcode_o, mem_resp_addr_o,
           mem_resp_size_o, mem_resp_payload_o, mem_resp_data_o
  );

endinterface

// File: rtl/bp_me_mock_mem_responder.sv
// Memory-side responder for CCE benches: one command in flight, fixed latency,
// small block store that aliases on the index bits above the byte offset.
//
// state  | meaning
// eReady | idle, accepting a command
// eWait  | counting down the fixed latency
// eResp  | response valid, held until yumi
module bp_me_mock_mem_responder
  #(parameter int addr_width_p    = 40
  , parameter int block_width_p   = 512
  , parameter int payload_width_p = 16
  , parameter int els_p           = 64
  , parameter int latency_p       = 4
  )
  (input  logic                         clk_i
  , input  logic                        reset_n_i
  , bp_me_mock_mem_responder_if.slave   mem_if
  , output logic [31:0]                 cmd_count_o
  );

  localparam int block_bytes_lp = block_width_p / 8;
  localparam int off_bits_lp    = $clog2(block_bytes_lp);
  localparam int idx_bits_lp    = $clog2(els_p);
  localparam logic [1:0] op_rd    = 2'd0;
  localparam logic [1:0] op_uc_rd = 2'd2;

  if (latency_p < 1) begin : g_lat_chk
    $error("bp_me_mock_mem_responder: latency_p must be >= 1");
  end

  typedef enum logic [1:0] {eReady, eWait, eResp} state_e;
  state_e state_r, state_n;

  logic [block_width_p-1:0]   mem_r [els_p];
  logic [31:0]                cnt_r;
  logic [1:0]                 op_r;
  logic [addr_width_p-1:0]    addr_r;
  logic [2:0]                 size_r;
  logic [payload_width_p-1:0] payload_r;
  logic [block_width_p-1:0]   data_r;

  logic                       ready, resp_v, accept, form, from_cmd;
  logic [1:0]                 form_op;
  logic [2:0]                 form_size;
  logic [off_bits_lp-1:0]     form_off;
  logic [idx_bits_lp-1:0]     form_idx, cmd_idx;
  logic [block_width_p-1:0]   wr_block, rd_data, form_blk;
  int                         wr_nb, wr_base, rd_nb, rd_base;

  // Oversized uncached sizes collapse to a full-block access.
  function automatic int nbytes_f(input logic [2:0] size);
    int s;
    s = int'(size);
    if (s > off_bits_lp) s = off_bits_lp;
    return 1 << s;
  endfunction

  function automatic int base_f(input logic [off_bits_lp-1:0] off, input int nb);
    return int'(off) & ~(nb - 1);
  endfunction

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= eReady;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    ready   = 1'b0;
    resp_v  = 1'b0;
    form    = 1'b0;
    unique case (state_r)
      eReady: begin
        ready = reset_n_i;
        if (mem_if.mem_cmd_v_i && reset_n_i) begin
          state_n = (latency_p == 1) ? eResp : eWait;
          form    = (latency_p == 1);
        end
      end
      eWait: begin
        if (cnt_r == 32'd0) begin
          state_n = eResp;
          form    = 1'b1;
        end
      end
      eResp: begin
        resp_v = 1'b1;
        if (mem_if.mem_resp_yumi_i) state_n = eReady;
      end
      default: state_n = eReady;
    endcase
  end

  assign accept = ready & mem_if.mem_cmd_v_i;
  assign cmd_idx = mem_if.mem_cmd_addr_i[off_bits_lp +: idx_bits_lp];

  // With latency 1 the response forms in the accept cycle, before the latch.
  assign from_cmd  = (state_r == eReady);
  assign form_op   = from_cmd ? mem_if.mem_cmd_opcode_i : op_r;
  assign form_size = from_cmd ? mem_if.mem_cmd_size_i : size_r;
  assign form_off  = from_cmd ? mem_if.mem_cmd_addr_i[off_bits_lp-1:0] : addr_r[off_bits_lp-1:0];
  assign form_idx  = from_cmd ? cmd_idx : addr_r[off_bits_lp +: idx_bits_lp];
  assign form_blk  = mem_r[form_idx];

  always_comb begin
    wr_nb    = nbytes_f(mem_if.mem_cmd_size_i);
    wr_base  = base_f(mem_if.mem_cmd_addr_i[off_bits_lp-1:0], wr_nb);
    wr_block = mem_r[cmd_idx];
    if (mem_if.mem_cmd_opcode_i[1] == 1'b0) begin
      wr_block = mem_if.mem_cmd_data_i;
    end else begin
      for (int b = 0; b < block_bytes_lp; b++) begin
        if (b >= wr_base && b < wr_base + wr_nb)
          wr_block[8*b +: 8] = mem_if.mem_cmd_data_i[8*(b-wr_base) +: 8];
      end
    end
  end

  always_comb begin
    rd_nb   = nbytes_f(form_size);
    rd_base = base_f(form_off, rd_nb);
    rd_data = '0;
    if (form_op == op_rd) begin
      rd_data = form_blk;
    end else if (form_op == op_uc_rd) begin
      for (int b = 0; b < block_bytes_lp; b++) begin
        if (b < rd_nb) rd_data[8*b +: 8] = form_blk[8*(rd_base+b) +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_r       <= '0;
      op_r        <= '0;
      addr_r      <= '0;
      size_r      <= '0;
      payload_r   <= '0;
      data_r      <= '0;
      cmd_count_o <= '0;
      for (int i = 0; i < els_p; i++) mem_r[i] <= '0;
    end else begin
      if (accept) begin
        op_r      <= mem_if.mem_cmd_opcode_i;
        addr_r    <= mem_if.mem_cmd_addr_i;
        size_r    <= mem_if.mem_cmd_size_i;
        payload_r <= mem_if.mem_cmd_payload_i;
        cnt_r     <= 32'(latency_p - 2);
        if (mem_if.mem_cmd_opcode_i[0]) mem_r[cmd_idx] <= wr_block;
      end else if (state_r == eWait && cnt_r != 32'd0) begin
        cnt_r <= cnt_r - 32'd1;
      end
      if (form) data_r <= rd_data;
      if (resp_v && mem_if.mem_resp_yumi_i) cmd_count_o <= cmd_count_o + 32'd1;
    end
  end

  assign mem_if.mem_cmd_ready_o    = ready;
  assign mem_if.mem_resp_v_o       = resp_v;
  assign mem_if.mem_resp_opcode_o  = op_r;
  assign mem_if.mem_resp_addr_o    = addr_r;
  assign mem_if.mem_resp_size_o    = size_r;
  assign mem_if.mem_resp_payload_o = payload_r;
  assign mem_if.mem_resp_data_o    = data_r;

  assert property (@(posedge clk_i) disable iff (!reset_n_i)
                   mem_if.mem_resp_yumi_i |-> mem_if.mem_resp_v_o)
    else $error("bp_me_mock_mem_responder: yumi without valid");

endmodule

// File: tb/tb_bp_me_mock_mem_responder.sv
// Directed bench for bp_me_mock_mem_responder: vector table plus hand-written
// backpressure and mid-latency reset sequences.
module tb_bp_me_mock_mem_responder;

  localparam int lat_lp = 4;
  localparam logic [511:0] blk_d = {16{32'hDEADBEEF}};
  localparam logic [511:0] blk_p = {8{64'h0011223344556677}};
  localparam logic [511:0] blk_q = {16{32'hCAFEF00D}};

  typedef struct {
    logic [1:0]   op;
    logic [39:0]  addr;
    logic [2:0]   size;
    logic [15:0]  payload;
    logic [511:0] data;
    logic [511:0] exp;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [31:0] cmd_count_o;
  int          checks = 0;
  int          errors = 0;
  int          exp_count = 0;
  vec_t        vecs [15];

  always #5 clk_i = ~clk_i;

  bp_me_mock_mem_responder_if mem_if ();

  bp_me_mock_mem_responder dut (
    .clk_i       (clk_i),
    .reset_n_i   (reset_n_i),
    .mem_if      (mem_if.slave),
    .cmd_count_o (cmd_count_o)
  );

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_cmd(input vec_t v);
    int n;
    mem_if.mem_cmd_v_i       = 1'b1;
    mem_if.mem_cmd_opcode_i  = v.op;
    mem_if.mem_cmd_addr_i    = v.addr;
    mem_if.mem_cmd_size_i    = v.size;
    mem_if.mem_cmd_payload_i = v.payload;
    mem_if.mem_cmd_data_i    = v.data;
    n = 0;
    while (!mem_if.mem_cmd_ready_o && n < 50) begin
      @(posedge clk_i); #1;
      n++;
    end
    chk("cmd_ready_wait", mem_if.mem_cmd_ready_o, 1'b1);
    @(posedge clk_i); #1;
    mem_if.mem_cmd_v_i = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!mem_if.mem_resp_v_o && lat < 50) begin
      @(posedge clk_i); #1;
      lat++;
    end
  endtask

  task automatic yumi_resp();
    mem_if.mem_resp_yumi_i = 1'b1;
    @(posedge clk_i); #1;
    mem_if.mem_resp_yumi_i = 1'b0;
    exp_count++;
    chk("ready_after_yumi", mem_if.mem_cmd_ready_o, 1'b1);
    chk("v_after_yumi", mem_if.mem_resp_v_o, 1'b0);
    chk("cmd_count", cmd_count_o, exp_count);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    send_cmd(v);
    wait_resp(lat);
    chk("latency", lat, lat_lp);
    chk("ready_in_resp", mem_if.mem_cmd_ready_o, 1'b0);
    chk("resp_opcode", mem_if.mem_resp_opcode_o, v.op);
    chk("resp_addr", mem_if.mem_resp_addr_o, v.addr);
    chk("resp_size", mem_if.mem_resp_size_o, v.size);
    chk("resp_payload", mem_if.mem_resp_payload_o, v.payload);
    chk("resp_data", mem_if.mem_resp_data_o, v.exp);
    if (mem_if.mem_resp_v_o) yumi_resp();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   lat;
    bit   saw_v;

    vecs[0]  = '{2'd0, 40'h0,          3'd6, 16'h0001, '0, '0};
    vecs[1]  = '{2'd1, 40'h40,         3'd6, 16'h0002, blk_d, '0};
    vecs[2]  = '{2'd0, 40'h40,         3'd6, 16'h1234, '0, blk_d};
    vecs[3]  = '{2'd3, 40'h86,         3'd1, 16'h0004, {{31{16'hFFFF}}, 16'hA5C3}, '0};
    vecs[4]  = '{2'd2, 40'h86,         3'd1, 16'h0005, '0, 512'hA5C3};
    vecs[5]  = '{2'd0, 40'h80,         3'd6, 16'h0006, '0, 512'hA5C3_0000_0000_0000};
    vecs[6]  = '{2'd1, 40'h0,          3'd6, 16'h0007, blk_p, '0};
    vecs[7]  = '{2'd0, 40'h1000,       3'd6, 16'h0008, '0, blk_p};
    vecs[8]  = '{2'd2, 40'h1003,       3'd0, 16'h0009, '0, 512'h44};
    vecs[9]  = '{2'd2, 40'h7,          3'd2, 16'h000A, '0, 512'h0011_2233};
    vecs[10] = '{2'd2, 40'h40,         3'd7, 16'h000B, '0, blk_d};
    vecs[11] = '{2'd3, 40'hC0,         3'd6, 16'h000C, blk_q, '0};
    vecs[12] = '{2'd3, 40'h45,         3'd0, 16'h000D, {{63{8'hFF}}, 8'h11}, '0};
    vecs[13] = '{2'd2, 40'h44,         3'd2, 16'h000E, '0, 512'hDEAD_11EF};
    vecs[14] = '{2'd2, 40'hFF_0000_0040, 3'd0, 16'h000F, '0, 512'hEF};

    reset_n_i                = 1'b0;
    mem_if.mem_cmd_v_i       = 1'b0;
    mem_if.mem_cmd_opcode_i  = '0;
    mem_if.mem_cmd_addr_i    = '0;
    mem_if.mem_cmd_size_i    = '0;
    mem_if.mem_cmd_payload_i = '0;
    mem_if.mem_cmd_data_i    = '0;
    mem_if.mem_resp_yumi_i   = 1'b0;
    #1;
    chk("ready_in_reset", mem_if.mem_cmd_ready_o, 1'b0);
    chk("v_in_reset", mem_if.mem_resp_v_o, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    chk("ready_after_reset", mem_if.mem_cmd_ready_o, 1'b1);
    chk("v_after_reset", mem_if.mem_resp_v_o, 1'b0);
    chk("count_after_reset", cmd_count_o, 32'd0);
    chk("resp_addr_reset", mem_if.mem_resp_addr_o, '0);
    chk("resp_data_reset", mem_if.mem_resp_data_o, '0);
    chk("resp_payload_reset", mem_if.mem_resp_payload_o, '0);

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Backpressure: response held for 10 cycles while an ignored write is offered.
    v = '{2'd0, 40'hC0, 3'd6, 16'hBEEF, '0, blk_q};
    send_cmd(v);
    wait_resp(lat);
    chk("bp_latency", lat, lat_lp);
    mem_if.mem_cmd_v_i      = 1'b1;
    mem_if.mem_cmd_opcode_i = 2'd1;
    mem_if.mem_cmd_addr_i   = 40'hC0;
    mem_if.mem_cmd_data_i   = '0;
    for (int c = 0; c < 10; c++) begin
      chk("bp_v", mem_if.mem_resp_v_o, 1'b1);
      chk("bp_ready", mem_if.mem_cmd_ready_o, 1'b0);
      chk("bp_data", mem_if.mem_resp_data_o, blk_q);
      chk("bp_addr", mem_if.mem_resp_addr_o, 40'hC0);
      chk("bp_payload", mem_if.mem_resp_payload_o, 16'hBEEF);
      @(posedge clk_i); #1;
    end
    mem_if.mem_cmd_v_i = 1'b0;
    yumi_resp();
    run_vec('{2'd0, 40'hC0, 3'd6, 16'h0010, '0, blk_q});

    // Reset while the latency counter is running drops the command and clears the store.
    v = '{2'd0, 40'h40, 3'd6, 16'h0011, '0, '0};
    send_cmd(v);
    @(posedge clk_i); #1;
    reset_n_i = 1'b0;
    #1;
    chk("rst_wait_v", mem_if.mem_resp_v_o, 1'b0);
    chk("rst_wait_ready", mem_if.mem_cmd_ready_o, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n_i = 1'b1;
    exp_count = 0;
    saw_v = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk_i); #1;
      if (mem_if.mem_resp_v_o) saw_v = 1'b1;
    end
    chk("rst_no_resp", saw_v, 1'b0);
    chk("rst_count", cmd_count_o, 32'd0);
    chk("rst_resp_addr", mem_if.mem_resp_addr_o, '0);
    chk("rst_ready", mem_if.mem_cmd_ready_o, 1'b1);
    run_vec('{2'd0, 40'h40,   3'd6, 16'h0012, '0, '0});
    run_vec('{2'd2, 40'h1003, 3'd0, 16'h0013, '0, '0});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
